// File: rtl/vector_mem_pkg.sv
// Shared types and helpers for the vector memory sequencer.
package vector_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        STORE,
        DONE
    } seq_state_e;

    // Beat counter width for a given lane count.
    function automatic int beat_w(int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // LSB position of a lane inside a packed vector.
    function automatic int unsigned lane_lsb(int unsigned lane, int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Single-port scalar data memory bus driven by the sequencer.
interface vector_mem_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  memWriteEnable;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic [DATA_WIDTH-1:0] memReadData;

    modport master (
        output memAddr, memWriteEnable, memWriteData,
        input  memReadData
    );

    modport slave (
        input  memAddr, memWriteEnable, memWriteData,
        output memReadData
    );
endinterface

// File: rtl/vector_mem_sequencer_lane_beat_counter.sv
// Beat counter walking the lanes of one vector access.
module lane_beat_counter
    import vector_mem_pkg::*;
#(
    parameter int LANES = 4,
    localparam int BW   = beat_w(LANES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [BW-1:0] beat,
    output logic          last
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            beat <= '0;
        end else if (enable) begin
            beat <= beat + BW'(1);
        end
    end

    assign last = (beat == BW'(LANES - 1));
endmodule

// File: rtl/vector_mem_sequencer.sv
// Serialises a vector load/store into single-element memory beats and stalls M meanwhile.
module vector_mem_sequencer
    import vector_mem_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        startLoadM,
    input  logic                        startStoreM,
    input  logic [ADDR_WIDTH-1:0]       baseAddrM,
    input  logic [LANES*DATA_WIDTH-1:0] storeDataM,
    vector_mem_sequencer_if.master      mem,
    output logic                        stallM,
    output logic [LANES*DATA_WIDTH-1:0] loadDataWB,
    output logic                        loadValidWB,
    output logic                        busy
);
    localparam int BW = beat_w(LANES);

    seq_state_e                  state;
    logic [ADDR_WIDTH-1:0]       base;
    logic [LANES*DATA_WIDTH-1:0] store_vec;
    logic                        is_load;
    logic [BW-1:0]               beat;
    logic [BW-1:0]               prev_beat;
    logic                        last_beat;

    lane_beat_counter #(.LANES(LANES)) u_beat (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable ((state == LOAD) || (state == STORE)),
        .beat   (beat),
        .last   (last_beat)
    );

    // Read data lags the address by one cycle, so a load beat fills the previous lane.
    assign prev_beat = beat - BW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base       <= '0;
            store_vec  <= '0;
            is_load    <= 1'b0;
            loadDataWB <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startLoadM) begin
                        base    <= baseAddrM;
                        is_load <= 1'b1;
                        state   <= LOAD;
                    end else if (startStoreM) begin
                        base      <= baseAddrM;
                        store_vec <= storeDataM;
                        is_load   <= 1'b0;
                        state     <= STORE;
                    end
                end
                LOAD: begin
                    if (beat != '0)
                        loadDataWB[lane_lsb(32'(prev_beat), DATA_WIDTH) +: DATA_WIDTH] <= mem.memReadData;
                    if (last_beat) state <= DRAIN;
                end
                DRAIN: begin
                    loadDataWB[(LANES-1)*DATA_WIDTH +: DATA_WIDTH] <= mem.memReadData;
                    state <= DONE;
                end
                STORE: begin
                    if (last_beat) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallM             = 1'b0;
        mem.memAddr        = '0;
        mem.memWriteEnable = 1'b0;
        mem.memWriteData   = '0;
        case (state)
            IDLE:  stallM = startLoadM | startStoreM;
            LOAD: begin
                stallM      = 1'b1;
                mem.memAddr = base + ADDR_WIDTH'(beat);
            end
            DRAIN: stallM = 1'b1;
            STORE: begin
                stallM             = 1'b1;
                mem.memAddr        = base + ADDR_WIDTH'(beat);
                mem.memWriteEnable = 1'b1;
                mem.memWriteData   = store_vec[lane_lsb(32'(beat), DATA_WIDTH) +: DATA_WIDTH];
            end
            default: stallM = 1'b0;
        endcase
    end

    assign loadValidWB = (state == DONE) && is_load;
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench: stimulus pushes expected writes/loads, a negedge monitor pops and compares.
module tb_vector_mem_sequencer;
    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int AW    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              startLoadM, startStoreM;
    logic [AW-1:0]     baseAddrM;
    logic [LANES*DW-1:0] storeDataM;
    logic              stallM, loadValidWB, busy;
    logic [LANES*DW-1:0] loadDataWB;

    int checks = 0;
    int errors = 0;

    logic [AW+DW-1:0]    exp_wr[$];
    logic [LANES*DW-1:0] exp_ld[$];
    logic [DW-1:0]       mem [0:65535];

    vector_mem_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    vector_mem_sequencer #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .startLoadM  (startLoadM),
        .startStoreM (startStoreM),
        .baseAddrM   (baseAddrM),
        .storeDataM  (storeDataM),
        .mem         (mem_bus.master),
        .stallM      (stallM),
        .loadDataWB  (loadDataWB),
        .loadValidWB (loadValidWB),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: read data valid one cycle after the address.
    always @(posedge clk) begin
        if (mem_bus.memWriteEnable) mem[mem_bus.memAddr] <= mem_bus.memWriteData;
        mem_bus.memReadData <= mem[mem_bus.memAddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_bus.memWriteEnable) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got write %0h@%0h expected none", mem_bus.memWriteData, mem_bus.memAddr);
                end else begin
                    check("wr_beat", 64'({mem_bus.memAddr, mem_bus.memWriteData}), 64'(exp_wr.pop_front()));
                end
            end
            if (loadValidWB) begin
                if (exp_ld.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ld_unexpected: got load %0h expected none", loadDataWB);
                end else begin
                    check("ld_data", 64'(loadDataWB), 64'(exp_ld.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stall"}, 64'(stallM), 64'(0));
        check({tag, "_addr"},  64'(mem_bus.memAddr), 64'(0));
        check({tag, "_we"},    64'(mem_bus.memWriteEnable), 64'(0));
        check({tag, "_wdata"}, 64'(mem_bus.memWriteData), 64'(0));
        check({tag, "_valid"}, 64'(loadValidWB), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
    endtask

    // both=1 holds startLoadM and startStoreM through DONE.
    task automatic run_load(input logic [AW-1:0] base, input logic [LANES*DW-1:0] exp, input bit both);
        step();
        startLoadM = 1'b1; startStoreM = both; baseAddrM = base; storeDataM = 32'hA5A5A5A5;
        exp_ld.push_back(exp);
        #1;
        check("ld_t0_busy", 64'(busy), 64'(0));
        check("ld_t0_stall", 64'(stallM), 64'(1));
        for (int k = 1; k <= LANES; k++) begin
            step();
            if (!both) begin startLoadM = 1'b0; startStoreM = 1'b0; end
            #1;
            check("ld_addr", 64'(mem_bus.memAddr), 64'(16'(base + 16'(k - 1))));
            check("ld_stall", 64'(stallM), 64'(1));
            check("ld_we", 64'(mem_bus.memWriteEnable), 64'(0));
        end
        step(); #1;
        check("ld_drain_stall", 64'(stallM), 64'(1));
        check("ld_drain_valid", 64'(loadValidWB), 64'(0));
        step(); #1;
        check("ld_done_stall", 64'(stallM), 64'(0));
        check("ld_done_valid", 64'(loadValidWB), 64'(1));
        check("ld_done_busy", 64'(busy), 64'(1));
    endtask

    task automatic run_store(input logic [AW-1:0] base, input logic [LANES*DW-1:0] data);
        logic [LANES*DW-1:0] v;
        step();
        startLoadM = 1'b0; startStoreM = 1'b1; baseAddrM = base; storeDataM = data;
        v = data;
        for (int k = 0; k < LANES; k++)
            exp_wr.push_back({16'(base + 16'(k)), v[k*DW +: DW]});
        #1;
        check("st_t0_busy", 64'(busy), 64'(0));
        check("st_t0_stall", 64'(stallM), 64'(1));
        for (int k = 0; k < LANES; k++) begin
            step();
            startStoreM = 1'b0;
            #1;
            check("st_addr", 64'(mem_bus.memAddr), 64'(16'(base + 16'(k))));
            check("st_wdata", 64'(mem_bus.memWriteData), 64'(v[k*DW +: DW]));
            check("st_stall", 64'(stallM), 64'(1));
        end
        step(); #1;
        check("st_done_stall", 64'(stallM), 64'(0));
        check("st_done_valid", 64'(loadValidWB), 64'(0));
        check("st_done_we", 64'(mem_bus.memWriteEnable), 64'(0));
    endtask

    initial begin
        mem[16'h0010] <= 8'h11; mem[16'h0011] <= 8'h22;
        mem[16'h0012] <= 8'h33; mem[16'h0013] <= 8'h44;
        mem[16'hFFFE] <= 8'h55; mem[16'hFFFF] <= 8'h66;
        mem[16'h0000] <= 8'h77; mem[16'h0001] <= 8'h88;
        mem[16'h0020] <= 8'h9A; mem[16'h0021] <= 8'hBC;
        mem[16'h0022] <= 8'hDE; mem[16'h0023] <= 8'hF0;
    end

    initial begin
        reset = 1'b1; startLoadM = 1'b0; startStoreM = 1'b0;
        baseAddrM = '0; storeDataM = '0;
        step(); step();
        check_idle_outputs("rst");
        check("rst_ldata", 64'(loadDataWB), 64'(0));
        reset = 1'b0;
        step(); step();
        check_idle_outputs("post_rst");
        check("post_rst_ldata", 64'(loadDataWB), 64'(0));

        run_load(16'h0010, 32'h44332211, 1'b0);
        step(); #1;
        check("ld_hold_data", 64'(loadDataWB), 64'h44332211);
        check_idle_outputs("after_ld");

        run_store(16'h0100, 32'hDDCCBBAA);
        check("st_keeps_ldata", 64'(loadDataWB), 64'h44332211);

        run_load(16'hFFFE, 32'h88776655, 1'b0);
        run_load(16'h0100, 32'hDDCCBBAA, 1'b0);

        // Both starts held through DONE, then a fresh store in the next IDLE cycle.
        run_load(16'h0020, 32'hF0DEBC9A, 1'b1);
        run_store(16'h0200, 32'h04030201);

        // Reset in the middle of a load.
        step();
        startLoadM = 1'b1; baseAddrM = 16'h0010;
        step(); startLoadM = 1'b0;
        step(); reset = 1'b1; #1;
        check("mid_rst_busy_before", 64'(busy), 64'(1));
        step(); reset = 1'b0; #1;
        check_idle_outputs("mid_rst");
        check("mid_rst_ldata", 64'(loadDataWB), 64'(0));
        for (int i = 0; i < 8; i++) begin
            step();
            check("mid_rst_no_valid", 64'(loadValidWB), 64'(0));
        end

        check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
        check("ld_queue_empty", 64'(exp_ld.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
